// File: rtl/sm4_keygen_arbiter.sv
// Round-robin arbiter sharing one SM4 LFSR key generator among NUM_REQ consumers:
// sequences the generator enable, captures each key and delivers it over valid/ready.
module sm4_keygen_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADV_CYCLES    = 8,
  parameter int WARMUP_CYCLES = 128,
  localparam int GW           = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_key_ready,
  output logic [NUM_REQ-1:0] o_key_valid,
  output logic [127:0]       o_key_data,
  output logic [GW-1:0]      o_grant_id,
  output logic               o_keygen_en,
  input  logic [127:0]       i_key,
  output logic               o_busy,
  output logic               o_init_done,
  output logic [31:0]        o_key_count
);

  localparam int unsigned NR      = NUM_REQ;
  localparam int          CNT_MAX = (WARMUP_CYCLES > ADV_CYCLES) ? WARMUP_CYCLES : ADV_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WARM_LOAD = (WARMUP_CYCLES > 0) ? CW'(WARMUP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] ADV_LOAD  = CW'(ADV_CYCLES - 1);
  localparam logic          INIT_RST  = (WARMUP_CYCLES == 0);

  typedef enum logic [2:0] {
    S_WARMUP,
    S_IDLE,
    S_ADVANCE,
    S_CAPTURE,
    S_DELIVER
  } state_t;

  localparam state_t RST_STATE = (WARMUP_CYCLES > 0) ? S_WARMUP : S_IDLE;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [GW-1:0]        rr_ptr, rr_nx;
  logic [GW-1:0]        grant_nx;
  logic [GW-1:0]        winner, idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   valid_nx;
  logic [127:0]         data_nx;
  logic [31:0]          count_nx;
  logic                 init_nx;

  // Enable is a pure decode of the registered state so the generator never sees a glitch.
  assign o_keygen_en = (state == S_WARMUP) || (state == S_ADVANCE);
  assign o_busy      = (state != S_IDLE);

  // First requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = GW'((32'(rr_ptr) + i) % NR);
      if (!win_found && i_req[idx]) begin
        winner    = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rr_nx    = rr_ptr;
    grant_nx = o_grant_id;
    valid_nx = o_key_valid;
    data_nx  = o_key_data;
    count_nx = o_key_count;
    init_nx  = o_init_done;
    case (state)
      S_WARMUP: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
          init_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_IDLE: begin
        if (win_found) begin
          grant_nx = winner;
          cnt_nx   = ADV_LOAD;
          state_nx = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (cnt == '0) begin
          state_nx = S_CAPTURE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_CAPTURE: begin
        data_nx  = i_key;
        valid_nx = NUM_REQ'(1) << o_grant_id;
        state_nx = S_DELIVER;
      end
      S_DELIVER: begin
        if (i_key_ready[o_grant_id]) begin
          valid_nx = '0;
          count_nx = o_key_count + 32'd1;
          rr_nx    = GW'((32'(o_grant_id) + 32'd1) % NR);
          state_nx = S_IDLE;
        end
      end
      default: state_nx = RST_STATE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RST_STATE;
      cnt         <= WARM_LOAD;
      rr_ptr      <= '0;
      o_grant_id  <= '0;
      o_key_valid <= '0;
      o_key_data  <= '0;
      o_key_count <= '0;
      o_init_done <= INIT_RST;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rr_ptr      <= rr_nx;
      o_grant_id  <= grant_nx;
      o_key_valid <= valid_nx;
      o_key_data  <= data_nx;
      o_key_count <= count_nx;
      o_init_done <= init_nx;
    end
  end

endmodule

// File: tb/tb_sm4_keygen_arbiter.sv
// Randomized bench for sm4_keygen_arbiter against a timestamp-based transaction model
// of warm-up, grant, advance, capture and delivery.
module tb_sm4_keygen_arbiter;

  localparam int N   = 4;
  localparam int ADV = 8;
  localparam int W   = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, ready;
  logic [3:0]   key_valid;
  logic [127:0] key_data;
  logic [1:0]   grant_id;
  logic         keygen_en, busy, init_done;
  logic [31:0]  key_count;
  logic [127:0] gen_key = '0;

  int checks = 0;
  int errors = 0;

  // Model state: cycle index since reset release, cycle of the current grant (-1 = none).
  int           cyc;
  int           t_grant;
  int           m_gid, m_rr;
  logic [31:0]  m_count;
  logic [127:0] m_key, prev_key;
  bit           have_prev;

  sm4_keygen_arbiter #(
    .NUM_REQ(N),
    .ADV_CYCLES(ADV),
    .WARMUP_CYCLES(W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_key_ready(ready),
    .o_key_valid(key_valid),
    .o_key_data(key_data),
    .o_grant_id(grant_id),
    .o_keygen_en(keygen_en),
    .i_key(gen_key),
    .o_busy(busy),
    .o_init_done(init_done),
    .o_key_count(key_count)
  );

  always #5 clk = ~clk;

  // Stand-in generator: a fresh random key on every enabled edge.
  always @(posedge clk) begin
    if (keygen_en) gen_key <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_en",    128'(keygen_en), 128'(1));
    check("rst_busy",  128'(busy),      128'(1));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_data",  key_data,        128'(0));
    check("rst_gid",   128'(grant_id),  128'(0));
    check("rst_count", 128'(key_count), 128'(0));
    check("rst_init",  128'(init_done), 128'(0));
    cyc       = 0;
    t_grant   = -1;
    m_gid     = 0;
    m_rr      = 0;
    m_count   = '0;
    m_key     = '0;
    have_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic tick(input logic [3:0] rq, input logic [3:0] rd);
    int d;
    logic [3:0] exp_valid;
    req   = rq;
    ready = rd;
    @(negedge clk);
    d         = (t_grant >= 0) ? cyc - t_grant : -1;
    exp_valid = (d >= ADV + 2) ? (4'(1) << m_gid) : 4'd0;
    check("en",     128'(keygen_en), 128'((cyc < W) || (d >= 1 && d <= ADV)));
    check("busy",   128'(busy),      128'((cyc < W) || (t_grant >= 0)));
    check("init",   128'(init_done), 128'(cyc >= W));
    check("valid",  128'(key_valid), 128'(exp_valid));
    check("data",   key_data,        m_key);
    check("gid",    128'(grant_id),  128'(m_gid));
    check("count",  128'(key_count), 128'(m_count));
    check("onehot", 128'($countones(key_valid) <= 1), 128'(1));
    if (cyc >= W) begin
      if (t_grant < 0) begin
        for (int i = 0; i < N; i++) begin
          int idx;
          idx = (m_rr + i) % N;
          if (rq[idx]) begin
            m_gid   = idx;
            t_grant = cyc;
            break;
          end
        end
      end else if (d == ADV + 1) begin
        m_key = gen_key;
      end else if (d >= ADV + 2 && rd[m_gid]) begin
        if (have_prev) check("key_differs", 128'(key_data != prev_key), 128'(1));
        prev_key  = m_key;
        have_prev = 1'b1;
        m_count   = m_count + 32'd1;
        m_rr      = (m_gid + 1) % N;
        t_grant   = -1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ready = '0;
    #3;
    do_reset();

    // Warm-up with every requester asserted: no grant may happen early.
    for (int i = 0; i < W; i++) tick(4'b1111, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) tick(4'b0000, 4'b1111);

    // Single request to requester 2, ready held high.
    tick(4'b0100, 4'b1111);
    for (int i = 0; i < 12; i++) tick(4'b0000, 4'b1111);

    // All requesting with ready high: round-robin rotation over five keys.
    for (int i = 0; i < 5 * (ADV + 3); i++) tick(4'b1111, 4'b1111);
    for (int i = 0; i < 3; i++) tick(4'b0000, 4'b1111);

    // Backpressure on requester 1 while others keep requesting.
    tick(4'b0010, 4'b1101);
    for (int i = 0; i < ADV + 2 + 20; i++) tick(4'b1111, 4'b1101);
    tick(4'b0000, 4'b1111);
    tick(4'b0000, 4'b1111);

    // Requester 3 drops its request right after the grant.
    tick(4'b1000, 4'b0000);
    for (int i = 0; i < ADV + 6; i++) tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b1000);
    tick(4'b0000, 4'b0000);

    // Random traffic.
    for (int i = 0; i < 1500; i++) tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 20; i++) tick(4'b0000, 4'b1111);

    // Async reset in the middle of an advance, then warm-up reruns.
    tick(4'b0001, 4'b1111);
    for (int i = 0; i < 3; i++) tick(4'b0000, 4'b1111);
    #2;
    do_reset();
    for (int i = 0; i < W + 200; i++) tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
